// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and encodings for the MEM-stage memory controller.
package mem_stage_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    EW_WORD = 2'b00,
    EW_BYTE = 2'b01,
    EW_HALF = 2'b10
  } extr_word_e;

  typedef enum logic [1:0] {
    LH_NONE = 2'b00,
    LH_LO   = 2'b01,
    LH_HI   = 2'b10
  } lh_to_reg_e;

  // Writeback control captured with an access and replayed when the bus acks.
  typedef struct packed {
    logic             mem_to_reg;
    logic             reg_write;
    logic [1:0]       lh_sel;
    logic [1:0]       extr_word;
    logic             extr_signed;
    logic [REG_W-1:0] dst;
  } wb_ctl_t;

  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] a);
    case (width)
      EW_HALF: misaligned = a[0];
      EW_BYTE: misaligned = 1'b0;
      default: misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte/halfword select from a read word, with sign or zero extension.
module load_extract
  import mem_stage_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [1:0]        extr_word_i,
  input  logic              extr_signed_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (extr_word_i)
      EW_BYTE: data_o = {{24{extr_signed_i & byte_sel[7]}}, byte_sel};
      EW_HALF: data_o = {{16{extr_signed_i & half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues one bus access per load/store, stalls upstream
// until the ack, and produces the registered writeback for every instruction.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ld,
  input  logic              MemWrite,
  input  logic              Sb,
  input  logic              Sh,
  input  logic [1:0]        ExtrWord,
  input  logic              ExtrSigned,
  input  logic              MemToReg,
  input  logic              RegWrite,
  input  logic [1:0]        LHToReg,
  input  logic [REG_W-1:0]  write,
  input  logic [DATA_W-1:0] result_1,
  input  logic [DATA_W-1:0] regfile_out2,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              addr_err
);

  function automatic logic [1:0] access_width(input logic st, input logic sb, input logic sh,
                                              input logic [1:0] ew);
    if (st) access_width = sb ? EW_BYTE : (sh ? EW_HALF : EW_WORD);
    else    access_width = ew;
  endfunction

  function automatic logic [3:0] store_be(input logic sb, input logic sh, input logic [1:0] a);
    if (sb)      store_be = 4'b0001 << a;
    else if (sh) store_be = a[1] ? 4'b1100 : 4'b0011;
    else         store_be = 4'b1111;
  endfunction

  function automatic logic [DATA_W-1:0] store_data(input logic sb, input logic sh,
                                                   input logic [DATA_W-1:0] d);
    if (sb)      store_data = {4{d[7:0]}};
    else if (sh) store_data = {2{d[15:0]}};
    else         store_data = d;
  endfunction

  function automatic logic [DATA_W-1:0] wb_select(input logic [1:0] lh, input logic mtr,
                                                  input logic [DATA_W-1:0] ldd,
                                                  input logic [DATA_W-1:0] res,
                                                  input logic [DATA_W-1:0] lo_v,
                                                  input logic [DATA_W-1:0] hi_v);
    if (lh == LH_LO)      wb_select = lo_v;
    else if (lh == LH_HI) wb_select = hi_v;
    else if (mtr)         wb_select = ldd;
    else                  wb_select = res;
  endfunction

  state_e            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              we_q, we_d;
  wb_ctl_t           ctl_q, ctl_d;
  logic              wb_we_q, wb_we_d;
  logic [REG_W-1:0]  wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              addr_err_q, addr_err_d;

  logic              access, misal, start, stall, dst_valid;
  logic [DATA_W-1:0] ld_data;
  wb_ctl_t           ctl_new;

  assign access    = (ld | MemWrite) & ~flush;
  assign misal     = misaligned(access_width(MemWrite, Sb, Sh, ExtrWord), result_1[1:0]);
  assign start     = access & ~misal;
  assign dst_valid = (write != '0);

  assign ctl_new.mem_to_reg  = MemToReg;
  assign ctl_new.reg_write   = RegWrite & dst_valid;
  assign ctl_new.lh_sel      = LHToReg;
  assign ctl_new.extr_word   = ExtrWord;
  assign ctl_new.extr_signed = ExtrSigned;
  assign ctl_new.dst         = write;

  load_extract u_load_extract (
    .rdata_i       (mem_rdata),
    .addr_lo_i     (res_q[1:0]),
    .extr_word_i   (ctl_q.extr_word),
    .extr_signed_i (ctl_q.extr_signed),
    .data_o        (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    res_d      = res_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    ctl_d      = ctl_q;
    wb_we_d    = 1'b0;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_q;
    addr_err_d = 1'b0;
    stall      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BUSY;
          addr_d  = {result_1[DATA_W-1:2], 2'b00};
          res_d   = result_1;
          be_d    = store_be(MemWrite & Sb, MemWrite & Sh, result_1[1:0]);
          wdata_d = store_data(MemWrite & Sb, MemWrite & Sh, regfile_out2);
          we_d    = MemWrite;
          ctl_d   = ctl_new;
          stall   = 1'b1;
        end else begin
          // Non-memory, flushed or misaligned instruction: retire next cycle.
          addr_err_d = access & misal;
          wb_we_d    = RegWrite & dst_valid & ~flush & ~(access & misal);
          wb_reg_d   = write;
          wb_data_d  = wb_select(LHToReg, MemToReg, ld_data, result_1, lo, hi);
        end
      end
      ST_BUSY: begin
        stall = ~mem_ack;
        if (mem_ack) begin
          state_d = ST_IDLE;
          if (!flush) begin
            wb_we_d   = ctl_q.reg_write;
            wb_reg_d  = ctl_q.dst;
            wb_data_d = wb_select(ctl_q.lh_sel, ctl_q.mem_to_reg, ld_data, res_q, lo, hi);
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Bus request stays up until the slave acks; the data is dropped.
        stall = 1'b1;
        if (mem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      res_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      ctl_q      <= '0;
      wb_we_q    <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      res_q      <= res_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      ctl_q      <= ctl_d;
      wb_we_q    <= wb_we_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign mem_req   = (state_q != ST_IDLE);
  assign mem_we    = we_q & mem_req;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign mem_stall = stall & ~rst;
  assign wb_we     = wb_we_q;
  assign wb_reg    = wb_reg_q;
  assign wb_data   = wb_data_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  logic        clk, rst, flush, ld, MemWrite, Sb, Sh, ExtrSigned, MemToReg, RegWrite;
  logic [1:0]  ExtrWord, LHToReg;
  logic [5:0]  write;
  logic [31:0] result_1, regfile_out2, lo, hi, mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we, mem_stall, wb_we, addr_err;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_be;
  logic [5:0]  wb_reg;

  int checks = 0;
  int errors = 0;
  int stalls;

  mem_stage_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .ld(ld), .MemWrite(MemWrite), .Sb(Sb), .Sh(Sh),
    .ExtrWord(ExtrWord), .ExtrSigned(ExtrSigned), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .LHToReg(LHToReg), .write(write), .result_1(result_1), .regfile_out2(regfile_out2),
    .lo(lo), .hi(hi), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_stall(mem_stall), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; ld = 0; MemWrite = 0; Sb = 0; Sh = 0; ExtrWord = 2'b00; ExtrSigned = 0;
    MemToReg = 0; RegWrite = 0; LHToReg = 2'b00; write = '0; result_1 = '0;
    regfile_out2 = '0; lo = '0; hi = '0; mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", mem_we); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", mem_stall); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rst_wbwe got %b exp 0", wb_we); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_aerr got %b exp 0", addr_err); end
    checks++; if ({mem_addr, mem_be, mem_wdata} !== 68'h0) begin errors++;
      $display("FAIL rst_bus got %h/%b/%h exp 0", mem_addr, mem_be, mem_wdata); end
    checks++; if ({wb_reg, wb_data} !== 38'h0) begin errors++;
      $display("FAIL rst_wb got %h/%h exp 0", wb_reg, wb_data); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d exp 0", dut.state_q); end
    rst = 0;
    tick();
  endtask

  task automatic test_store_byte();
    MemWrite = 1; Sb = 1; result_1 = 32'h0000_1003; regfile_out2 = 32'h0000_00AB;
    stalls = 0;
    #1;
    if (mem_stall) stalls++;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sb_req_idle got %b exp 0", mem_req); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++;
      $display("FAIL sb_req_we got %b%b exp 11", mem_req, mem_we); end
    checks++; if (mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr got %h exp 00001000", mem_addr); end
    checks++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b exp 1000", mem_be); end
    checks++; if (mem_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata got %h exp ababab ab", mem_wdata); end
    mem_ack = 1;
    #1;
    if (mem_stall) stalls++;
    checks++; if (stalls !== 1) begin errors++; $display("FAIL sb_stall_cycles got %0d exp 1", stalls); end
    tick();
    clear_inputs();
    #1;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++;
      $display("FAIL sb_done got %b%b exp 00", mem_req, mem_we); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL sb_wbwe got %b exp 0", wb_we); end
    tick();
  endtask

  task automatic test_store_half();
    MemWrite = 1; Sh = 1; result_1 = 32'h0000_1002; regfile_out2 = 32'h1234_BEEF;
    tick();
    checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", mem_be); end
    checks++; if (mem_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got %h exp beefbeef", mem_wdata); end
    mem_ack = 1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_load_byte_signed();
    ld = 1; ExtrWord = 2'b01; ExtrSigned = 1; MemToReg = 1; RegWrite = 1; write = 6'd7;
    result_1 = 32'h0000_2001;
    stalls = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (mem_stall) stalls++;
      tick();
    end
    checks++; if (mem_addr !== 32'h0000_2000 || mem_we !== 1'b0) begin errors++;
      $display("FAIL lb_bus got %h we %b exp 00002000 we 0", mem_addr, mem_we); end
    mem_ack = 1; mem_rdata = 32'h1234_F678;
    #1;
    if (mem_stall) stalls++;
    checks++; if (stalls !== 3) begin errors++; $display("FAIL lb_stall_cycles got %0d exp 3", stalls); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL lb_wb_early got %b exp 0", wb_we); end
    tick();
    clear_inputs();
    checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL lb_wbwe got %b exp 1", wb_we); end
    checks++; if (wb_data !== 32'hFFFF_FFF6) begin errors++; $display("FAIL lb_wbdata got %h exp fffffff6", wb_data); end
    checks++; if (wb_reg !== 6'd7) begin errors++; $display("FAIL lb_wbreg got %0d exp 7", wb_reg); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lb_req_after got %b exp 0", mem_req); end
    tick();
  endtask

  task automatic test_misalign();
    ld = 1; ExtrWord = 2'b10; MemToReg = 1; RegWrite = 1; write = 6'd3; result_1 = 32'h0000_2001;
    #1;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL lh_mis_stall got %b exp 0", mem_stall); end
    tick();
    clear_inputs();
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL lh_mis_aerr got %b exp 1", addr_err); end
    checks++; if (wb_we !== 1'b0 || mem_req !== 1'b0) begin errors++;
      $display("FAIL lh_mis_wb_req got %b%b exp 00", wb_we, mem_req); end
    tick();
    checks++; if (addr_err !== 1'b0 || mem_req !== 1'b0) begin errors++;
      $display("FAIL lh_mis_pulse got %b%b exp 00", addr_err, mem_req); end
    MemWrite = 1; result_1 = 32'h0000_1002;
    tick();
    clear_inputs();
    checks++; if (addr_err !== 1'b1 || mem_req !== 1'b0) begin errors++;
      $display("FAIL sw_mis got %b%b exp 10", addr_err, mem_req); end
    tick();
  endtask

  task automatic test_flush_drain();
    ld = 1; ExtrWord = 2'b00; MemToReg = 1; RegWrite = 1; write = 6'd9; result_1 = 32'h0000_3000;
    tick();
    flush = 1;
    #1;
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL fl_busy_stall got %b exp 1", mem_stall); end
    tick();
    clear_inputs();
    #1;
    checks++; if (dut.state_q !== ST_DRAIN) begin errors++; $display("FAIL fl_state got %0d exp 2", dut.state_q); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3000 || mem_stall !== 1'b1) begin errors++;
      $display("FAIL fl_drain got req %b addr %h stall %b exp 1 00003000 1", mem_req, mem_addr, mem_stall); end
    tick();
    mem_ack = 1; mem_rdata = 32'h5555_5555;
    #1;
    checks++; if (mem_req !== 1'b1 || wb_we !== 1'b0) begin errors++;
      $display("FAIL fl_ack_cycle got req %b wbwe %b exp 1 0", mem_req, wb_we); end
    tick();
    mem_ack = 0;
    #1;
    checks++; if (mem_req !== 1'b0 || wb_we !== 1'b0 || mem_stall !== 1'b0) begin errors++;
      $display("FAIL fl_done got req %b wbwe %b stall %b exp 000", mem_req, wb_we, mem_stall); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL fl_idle got %0d exp 0", dut.state_q); end
  endtask

  task automatic test_hilo_alu();
    LHToReg = 2'b10; hi = 32'hDEAD_BEEF; lo = 32'h0BAD_0BAD; RegWrite = 1; write = 6'd5;
    result_1 = 32'h0000_1234;
    #1;
    checks++; if (mem_stall !== 1'b0 || mem_req !== 1'b0) begin errors++;
      $display("FAIL hi_nomem got %b%b exp 00", mem_stall, mem_req); end
    tick();
    LHToReg = 2'b01; lo = 32'hCAFE_F00D; write = 6'd6;
    checks++; if (wb_data !== 32'hDEAD_BEEF || wb_reg !== 6'd5 || wb_we !== 1'b1) begin errors++;
      $display("FAIL hi_wb got %h r%0d we%b exp deadbeef r5 we1", wb_data, wb_reg, wb_we); end
    tick();
    LHToReg = 2'b00; result_1 = 32'h0000_0042; write = 6'd0;
    checks++; if (wb_data !== 32'hCAFE_F00D || wb_reg !== 6'd6) begin errors++;
      $display("FAIL lo_wb got %h r%0d exp cafef00d r6", wb_data, wb_reg); end
    tick();
    ld = 1; flush = 1; write = 6'd4; result_1 = 32'h0000_6000;
    checks++; if (wb_we !== 1'b0 || wb_data !== 32'h0000_0042) begin errors++;
      $display("FAIL r0_wb got we%b %h exp we0 00000042", wb_we, wb_data); end
    #1;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL flidle_stall got %b exp 0", mem_stall); end
    tick();
    clear_inputs();
    checks++; if (wb_we !== 1'b0 || mem_req !== 1'b0) begin errors++;
      $display("FAIL flidle_wb got %b%b exp 00", wb_we, mem_req); end
    tick();
  endtask

  task automatic test_back_to_back();
    ld = 1; MemToReg = 1; RegWrite = 1; write = 6'd1; result_1 = 32'h0000_5000;
    tick();
    mem_ack = 1; mem_rdata = 32'hAAAA_5555;
    tick();
    mem_ack = 0; ExtrWord = 2'b10; ExtrSigned = 1; write = 6'd2; result_1 = 32'h0000_5006;
    checks++; if (wb_we !== 1'b1 || wb_reg !== 6'd1 || wb_data !== 32'hAAAA_5555) begin errors++;
      $display("FAIL b2b_first got we%b r%0d %h exp we1 r1 aaaa5555", wb_we, wb_reg, wb_data); end
    #1;
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall got %b exp 1", mem_stall); end
    tick();
    checks++; if (mem_addr !== 32'h0000_5004 || wb_we !== 1'b0) begin errors++;
      $display("FAIL b2b_second_bus got %h we%b exp 00005004 we0", mem_addr, wb_we); end
    mem_ack = 1; mem_rdata = 32'h8001_1234;
    tick();
    clear_inputs();
    checks++; if (wb_data !== 32'hFFFF_8001 || wb_reg !== 6'd2 || wb_we !== 1'b1) begin errors++;
      $display("FAIL b2b_second_wb got %h r%0d we%b exp ffff8001 r2 we1", wb_data, wb_reg, wb_we); end
    tick();
  endtask

  task automatic test_reset_busy();
    ld = 1; RegWrite = 1; MemToReg = 1; write = 6'd8; result_1 = 32'h0000_4000;
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rb_busy_req got %b exp 1", mem_req); end
    rst = 1;
    #1;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rb_stall_in_rst got %b exp 0", mem_stall); end
    tick();
    rst = 0; clear_inputs(); mem_ack = 1; mem_rdata = 32'h7777_7777;
    #1;
    checks++; if ({mem_req, mem_we, mem_stall, wb_we, addr_err} !== 5'b0) begin errors++;
      $display("FAIL rb_ctrl got %b%b%b%b%b exp 00000", mem_req, mem_we, mem_stall, wb_we, addr_err); end
    checks++; if ({mem_addr, mem_be, mem_wdata, wb_reg, wb_data} !== 106'h0) begin errors++;
      $display("FAIL rb_data got %h %b %h %h %h exp 0", mem_addr, mem_be, mem_wdata, wb_reg, wb_data); end
    tick();
    mem_ack = 0;
    checks++; if (mem_req !== 1'b0 || wb_we !== 1'b0 || dut.state_q !== ST_IDLE) begin errors++;
      $display("FAIL rb_stray_ack got req %b wbwe %b st %0d exp 0 0 0", mem_req, wb_we, dut.state_q); end
    tick();
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_store_half();
    test_load_byte_signed();
    test_misalign();
    test_flush_drain();
    test_hilo_alu();
    test_back_to_back();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 SHALL expose the following ports, one per line: name  direction  width  meaning.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard the current MEM-stage instruction.
- ld  in  1  load instruction present.
- MemWrite  in  1  store instruction present.
- Sb, Sh  in  1 each  byte store / halfword store.
- ExtrWord  in  2  load width: 00 word, 01 byte, 10 halfword.
- ExtrSigned  in  1  1 = sign-extend, 0 = zero-extend.
- MemToReg  in  1  writeback selects load data.
- RegWrite  in  1  writeback enable.
- LHToReg  in  2  01 = LO, 10 = HI.
- write  in  6  destination register.
- result_1  in  32  ALU result / effective address.
- regfile_out2  in  32  store data.
- lo, hi  in  32 each  HI/LO values.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  32  word-aligned address.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  write data.
- mem_ack  in  1  request complete.
- mem_rdata  in  32  read word.
- mem_stall  out  1  hold upstream stage.
- wb_we  out  1  writeback enable.
- wb_reg  out  6  writeback register.
- wb_data  out  32  writeback data.
- addr_err  out  1  one-cycle misaligned-access pulse.

Function
REQ-003 SHALL implement the FSM IDLE -> BUSY -> IDLE, plus DRAIN.
REQ-004 An access is ld|MemWrite with flush=0.
- In IDLE with an aligned access: latch address/be/wdata/we, go to BUSY.
REQ-005 mem_req SHALL be 1 exactly while in BUSY or DRAIN.
- mem_addr/be/wdata/we SHALL stay stable until the cycle in which mem_ack=1.
REQ-006 mem_stall SHALL be combinational: (IDLE & aligned access) | (BUSY & !mem_ack) | DRAIN.
REQ-007 Minimum access latency SHALL be 2 cycles; each extra cycle without ack adds one.
REQ-008 Store byte enables SHALL be:
- Sb: 1<<addr[1:0], with the low byte replicated x4.
- Sh: addr[1] ? 1100 : 0011, with the low halfword replicated x2.
- Otherwise: 1111.
REQ-009 Loads SHALL select the byte/halfword by addr[1:0] from mem_rdata, then extend per ExtrSigned.
REQ-010 Misalignment SHALL be: halfword with addr[0]=1; word with addr[1:0]!=0.
- Response: pulse addr_err, no mem_req, wb_we=0, no stall.
REQ-011 wb_data SHALL use this priority:
- LHToReg=01 -> lo; LHToReg=10 -> hi.
- MemToReg -> extracted load data.
- Otherwise -> result_1.
REQ-012 Writeback outputs SHALL be registered.
- Non-memory instruction: valid the cycle after presentation.
- Memory access: valid the cycle after mem_ack.
REQ-013 wb_we SHALL equal RegWrite and SHALL be forced to 0 when write=0, on flush, or on addr_err.
REQ-014 flush in IDLE SHALL suppress the access and writeback.
REQ-015 flush in BUSY SHALL move the FSM to DRAIN.
- The bus request is held until ack; data is discarded; wb_we=0; then go to IDLE.
REQ-016 mem_ack outside BUSY/DRAIN SHALL be ignored.

Reset
REQ-017 rst SHALL force: state=IDLE; mem_req, mem_we, mem_stall, wb_we, addr_err = 0; mem_addr, mem_be, mem_wdata, wb_reg, wb_data = 0.
REQ-018 rst mid-BUSY SHALL abandon the request immediately.
- A late mem_ack after reset is ignored per REQ-016.

Structure
REQ-019 A shared package SHALL hold the FSM state enum, ExtrWord/LHToReg encodings and the data width.
REQ-020 One sub-module, load_extract, SHALL be the combinational byte/halfword select and extend.

Verification
REQ-021 sb, addr=0x1003, data=0x000000AB, ack after 1 cycle:
- mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x1000, stall for 1 cycle.
REQ-022 lb signed, addr=0x2001, rdata=0x1234F678, ack after 3 cycles:
- wb_data=0xFFFFFFF6, stall for 3 cycles, wb_we=1.
REQ-023 lh, addr=0x2001:
- addr_err=1, mem_req never asserted, wb_we=0.
REQ-024 lw in BUSY, flush asserted, ack 2 cycles later:
- DRAIN entered, mem_req held until ack, wb_we=0, IDLE next.
REQ-025 LHToReg=10, hi=0xDEADBEEF, write=5:
- wb_data=0xDEADBEEF and wb_reg=5 one cycle later, no mem_req.
REQ-026 rst asserted mid-BUSY, then stray mem_ack:
- All outputs 0, state IDLE, ack ignored.
